dcache_req_arbiter: RTL

Round-robin arbiter that shares one data-cache port among N_REQ requesters, such as a page-table walker, a prefetcher and a core-side port.
Tracks which requester owns the s1 and s2 pipeline stages, so that s1_kill goes out from the right owner and s2_nack/s2_xcpt come back to the right owner.
Appends a requester ID to the low bits of the request tag and routes responses back by that ID.
Sits between the requesters and the cache's memory-side request/response interface.

---
 rtl/dcache_req_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one data-cache port among N_REQ requesters.
// Tracks s1/s2 ownership for kill/nack routing and routes responses by tag ID.
module dcache_req_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          io_requestor_req_valid,
  output logic [N_REQ-1:0]          io_requestor_req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   io_requestor_req_bits_addr,
  input  logic [N_REQ*TAG_W-1:0]    io_requestor_req_bits_tag,
  input  logic [N_REQ-1:0]          io_requestor_s1_kill,
  output logic [N_REQ-1:0]          io_requestor_s2_nack,
  output logic [N_REQ-1:0]          io_requestor_s2_xcpt_ae_ld,
  output logic [N_REQ-1:0]          io_requestor_resp_valid,
  output logic [DATA_W-1:0]         io_requestor_resp_bits_data,
  output logic [TAG_W-1:0]          io_requestor_resp_bits_tag,
  input  logic                      io_mem_req_ready,
  output logic                      io_mem_req_valid,
  output logic [ADDR_W-1:0]         io_mem_req_bits_addr,
  output logic [TAG_W+ID_W-1:0]     io_mem_req_bits_tag,
  output logic                      io_mem_s1_kill,
  input  logic                      io_mem_s2_nack,
  input  logic                      io_mem_s2_xcpt_ae_ld,
  input  logic                      io_mem_resp_valid,
  input  logic [DATA_W-1:0]         io_mem_resp_bits_data,
  input  logic [TAG_W+ID_W-1:0]     io_mem_resp_bits_tag
);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;

  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   grant_hi, grant_lo;
  logic              found_hi;
  logic              fire;
  logic [ADDR_W-1:0] addr_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic              kill_sel;
  logic [ID_W-1:0]   resp_id;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (io_requestor_req_valid[i]) begin
        grant_lo = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          grant_hi = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  assign io_mem_req_valid = !reset && (|io_requestor_req_valid);
  assign fire             = io_mem_req_valid && io_mem_req_ready;

  always_comb begin
    addr_sel = '0;
    tag_sel  = '0;
    io_requestor_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        addr_sel = io_requestor_req_bits_addr[i*ADDR_W +: ADDR_W];
        tag_sel  = io_requestor_req_bits_tag[i*TAG_W +: TAG_W];
        io_requestor_req_ready[i] = fire;
      end
    end
  end

  assign io_mem_req_bits_addr = addr_sel;
  assign io_mem_req_bits_tag  = {tag_sel, grant};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
    s1_valid_d = fire;
    s1_id_d    = fire ? grant : s1_id_q;
    // Killed requests still advance so a late nack lands on the right owner.
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    s1_id_q <= s1_id_d;
    s2_id_q <= s2_id_d;
  end

  always_comb begin
    kill_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (s1_id_q == ID_W'(i)) kill_sel = io_requestor_s1_kill[i];
    end
  end

  assign io_mem_s1_kill = !reset && s1_valid_q && kill_sel;

  always_comb begin
    io_requestor_s2_nack       = '0;
    io_requestor_s2_xcpt_ae_ld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset && s2_valid_q && (s2_id_q == ID_W'(i))) begin
        io_requestor_s2_nack[i]       = io_mem_s2_nack;
        io_requestor_s2_xcpt_ae_ld[i] = io_mem_s2_xcpt_ae_ld;
      end
    end
  end

  // Response path is purely combinational; IDs beyond N_REQ match nobody.
  assign resp_id = io_mem_resp_bits_tag[ID_W-1:0];

  always_comb begin
    io_requestor_resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      io_requestor_resp_valid[i] = io_mem_resp_valid && (resp_id == ID_W'(i));
    end
  end

  assign io_requestor_resp_bits_tag  = io_mem_resp_bits_tag[TAG_W+ID_W-1:ID_W];
  assign io_requestor_resp_bits_data = io_mem_resp_bits_data;

endmodule
